// File: rtl/magnitude_sequencer.sv
// rtl/magnitude_sequencer.sv - multi-cycle floor(sqrt(re^2+im^2)) with one shared squarer and 1-bit/cycle root; optional MAG_OVF_FLAG_EN adds out_ovf
module magnitude_sequencer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mag
`ifdef MAG_OVF_FLAG_EN
    ,
    output logic              out_ovf
`endif
);

    localparam int RW = DATA_W / 2;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SQ_RE = 3'd1,
        SQ_IM = 3'd2,
        ADD   = 3'd3,
        ROOT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] re_r;
    logic [DATA_W-1:0] im_r;
    logic [DATA_W-1:0] sq_re;
    logic [DATA_W-1:0] sq_im;
    logic [DATA_W-1:0] sum;
    logic [RW-1:0]     root;
    logic [RW+1:0]     rem;
    logic [CW-1:0]     cnt;

    logic [DATA_W-1:0] mul_op;
    logic [DATA_W-1:0] prod_lo;
    logic [DATA_W-1:0] add_lo;
    logic [RW+3:0]     rem_sh;
    logic [RW+3:0]     trial;
    logic              take;
    logic [RW+1:0]     rem_nxt;
    logic [RW-1:0]     root_nxt;

    // The single multiplier is time-shared: real part in SQ_RE, imaginary part in SQ_IM
    assign mul_op = (state == SQ_IM) ? im_r : re_r;

`ifdef MAG_OVF_FLAG_EN
    logic signed [2*DATA_W-1:0] prod_full;
    logic                       prod_big;
    logic                       add_carry;
    logic                       ovf_acc;

    assign prod_full           = $signed(mul_op) * $signed(mul_op);
    assign prod_lo             = prod_full[DATA_W-1:0];
    assign prod_big            = |prod_full[2*DATA_W-1:DATA_W];
    assign {add_carry, add_lo} = {1'b0, sq_re} + {1'b0, sq_im};
`else
    // Low half of a square is the same for signed and unsigned operands
    assign prod_lo = mul_op * mul_op;
    assign add_lo  = sq_re + sq_im;
`endif

    // Restoring square-root step: bring down the next two radicand bits, try 4*root+1
    assign rem_sh   = {rem, sum[DATA_W-1 -: 2]};
    assign trial    = {2'b00, root, 2'b01};
    assign take     = (rem_sh >= trial);
    assign rem_nxt  = take ? (rem_sh[RW+1:0] - trial[RW+1:0]) : rem_sh[RW+1:0];
    assign root_nxt = {root[RW-2:0], take};

    // Sequencer: capture, square twice, add, iterate root, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_mag   <= '0;
            re_r      <= '0;
            im_r      <= '0;
            sq_re     <= '0;
            sq_im     <= '0;
            sum       <= '0;
            root      <= '0;
            rem       <= '0;
            cnt       <= '0;
`ifdef MAG_OVF_FLAG_EN
            ovf_acc   <= 1'b0;
            out_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        re_r     <= in_re;
                        im_r     <= in_im;
                        in_ready <= 1'b0;
                        state    <= SQ_RE;
                    end
                end
                SQ_RE: begin
                    sq_re   <= prod_lo;
`ifdef MAG_OVF_FLAG_EN
                    ovf_acc <= prod_big;
`endif
                    state   <= SQ_IM;
                end
                SQ_IM: begin
                    sq_im   <= prod_lo;
`ifdef MAG_OVF_FLAG_EN
                    ovf_acc <= ovf_acc | prod_big;
`endif
                    state   <= ADD;
                end
                ADD: begin
                    sum     <= add_lo;
`ifdef MAG_OVF_FLAG_EN
                    ovf_acc <= ovf_acc | add_carry;
`endif
                    rem     <= '0;
                    root    <= '0;
                    cnt     <= CW'(RW - 1);
                    state   <= ROOT;
                end
                ROOT: begin
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    sum  <= {sum[DATA_W-3:0], 2'b00};
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        out_mag   <= {{(DATA_W-RW){1'b0}}, root_nxt};
`ifdef MAG_OVF_FLAG_EN
                        out_ovf   <= ovf_acc;
`endif
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_magnitude_sequencer.sv
// tb/tb_magnitude_sequencer.sv - directed self-checking bench for magnitude_sequencer
module tb_magnitude_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mag;
`ifdef MAG_OVF_FLAG_EN
    logic        out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    magnitude_sequencer #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag)
`ifdef MAG_OVF_FLAG_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for out_valid after an accepting edge; returns edge count, 0 on timeout
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (out_mag !== 16'd0) begin errors++; $display("FAIL reset_out_mag got %0d expected 0", out_mag); end
`ifdef MAG_OVF_FLAG_EN
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b expected 0", out_ovf); end
`endif
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic run_op(input logic [15:0] re, input logic [15:0] im,
                          input logic [15:0] exp_mag, input logic exp_ovf, input string name);
        int lat;
        @(negedge clk);
        in_re = re; in_im = im; in_valid = 1'b1; out_ready = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_idle_ready got %b expected 1", name, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_busy_ready got %b expected 0", name, in_ready); end
        wait_valid(lat);
        checks++; if (lat != 11) begin errors++; $display("FAIL %s_latency got %0d expected 11", name, lat); end
        checks++; if (out_mag !== exp_mag) begin errors++; $display("FAIL %s_mag got %0d expected %0d", name, out_mag, exp_mag); end
`ifdef MAG_OVF_FLAG_EN
        checks++; if (out_ovf !== exp_ovf) begin errors++; $display("FAIL %s_ovf got %b expected %b", name, out_ovf, exp_ovf); end
`else
        if (exp_ovf === 1'bx) $display("unexpected x");
`endif
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL %s_release got valid=%b ready=%b expected 0/1", name, out_valid, in_ready); end
    endtask

    task automatic test_vectors;
        run_op(16'd3, 16'd4, 16'd5, 1'b0, "v_3_4");
        run_op(-16'sd3, -16'sd4, 16'd5, 1'b0, "v_m3_m4");
        run_op(16'd0, 16'd0, 16'd0, 1'b0, "v_0_0");
        run_op(16'd200, 16'd100, 16'd223, 1'b0, "v_200_100");
        run_op(16'd181, 16'd181, 16'd255, 1'b0, "v_181_181");
        run_op(16'd256, 16'd0, 16'd0, 1'b1, "v_256_0");
        run_op(16'd200, 16'd200, 16'd120, 1'b1, "v_200_200");
        run_op(16'h8000, 16'd3, 16'd3, 1'b1, "v_min_3");
        run_op(16'd255, 16'd0, 16'd255, 1'b0, "v_255_0");
    endtask

    task automatic test_stall;
        int lat;
        @(negedge clk);
        in_re = 16'd3; in_im = 16'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        checks++; if (lat != 11) begin errors++; $display("FAIL stall_latency got %0d expected 11", lat); end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin in_re = 16'd6; in_im = 16'd8; in_valid = 1'b1; end
            if (i == 6) in_valid = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_mag !== 16'd5 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got valid=%b mag=%0d ready=%b expected 1/5/0", i, out_valid, out_mag, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_mag !== 16'd5) begin errors++; $display("FAIL stall_no_ghost got ready=%b mag=%0d expected 1/5", in_ready, out_mag); end
    endtask

    task automatic test_back_to_back;
        int lat;
        int seen;
        @(negedge clk);
        in_re = 16'd3; in_im = 16'd4; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_re = 16'd6; in_im = 16'd8;
        wait_valid(lat);
        checks++; if (lat != 11 || out_mag !== 16'd5) begin errors++; $display("FAIL b2b_first got lat=%0d mag=%0d expected 11/5", lat, out_mag); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got ready=%b expected 0", in_ready); end
        wait_valid(lat);
        checks++; if (lat != 11 || out_mag !== 16'd10) begin errors++; $display("FAIL b2b_second got lat=%0d mag=%0d expected 11/10", lat, out_mag); end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL b2b_no_dup got %0d extra valid cycles expected 0", seen); end
    endtask

    task automatic test_reset_mid_root;
        int seen;
        @(negedge clk);
        in_re = 16'd3; in_im = 16'd4; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mag !== 16'd0) begin
            errors++;
            $display("FAIL midroot_reset got ready=%b valid=%b mag=%0d expected 1/0/0", in_ready, out_valid, out_mag);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || in_ready !== 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midroot_quiet got %0d bad cycles expected 0", seen); end
        run_op(16'd5, 16'd12, 16'd13, 1'b0, "v_5_12");
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_stall;
        test_back_to_back;
        test_reset_mid_root;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
